// File: rtl/ctrl_frame_tx_engine.sv
// ctrl_frame_tx_engine: streams a RAM-held control frame byte-by-byte into a subset of PHY-TX FIFOs
module ctrl_frame_tx_engine #(
    parameter int NPORTS = 4,
    parameter int RAM_AW = 4,
    localparam int LEN_W = RAM_AW + 2
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              iomem_valid,
    output logic              iomem_ready,
    input  logic [3:0]        iomem_wstrb,
    input  logic [31:0]       iomem_addr,
    input  logic [31:0]       iomem_wdata,
    output logic [31:0]       iomem_rdata,
    input  logic [3:0]        cfg_we,
    input  logic [31:0]       cfg_di,
    output logic [31:0]       cfg_do,
    output logic [7:0]        fifo_din,
    output logic              fifo_del,
    input  logic [NPORTS-1:0] fifo_afull,
    output logic [NPORTS-1:0] fifo_wren,
    output logic              irq
);
    typedef enum logic [1:0] {IDLE, WAIT, TX, END} state_t;
    state_t state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
    logic [NPORTS-1:0] mask_q, mask_d, wren_q, wren_d;
    logic [7:0] din_q, din_d, frame_byte;
    logic del_q, del_d, done_q, done_d, aborted_q, aborted_d, irq_en_q, irq_en_d;
    logic ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d, word;
    logic [31:0] mem_q [2**RAM_AW];
    logic [RAM_AW-1:0] widx;
    logic busy, tx_req, abort_req, blocked, bus_req, unused_ok;

    assign busy       = state_q != IDLE;
    assign tx_req     = cfg_we[3] & cfg_di[31];
    assign abort_req  = cfg_we[3] & cfg_di[28];
    assign blocked    = |(fifo_afull & mask_q);
    assign bus_req    = iomem_valid & ~ready_q;
    assign widx       = iomem_addr[RAM_AW+1:2];
    assign word       = mem_q[cnt_q[LEN_W-1:2]];
    assign frame_byte = word[{~cnt_q[1:0], 3'b000} +: 8];
    assign ready_d    = bus_req;
    assign rdata_d    = bus_req ? mem_q[widx] : rdata_q;
    assign unused_ok  = ^{iomem_addr, cfg_di, cfg_we};

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign fifo_din    = din_q;
    assign fifo_del    = del_q;
    assign fifo_wren   = wren_q;
    assign irq         = done_q & irq_en_q;

    // Config/status readback assembled from the live registers
    always_comb begin
        cfg_do = '0;
        cfg_do[30] = ~busy;
        cfg_do[29] = busy;
        cfg_do[27] = done_q;
        cfg_do[26] = aborted_q;
        cfg_do[25] = irq_en_q;
        cfg_do[16 +: NPORTS] = mask_q;
        cfg_do[LEN_W-1:0] = len_q;
    end

    // RW config fields take byte-lane writes only while idle, so they double as the frame's latched mask/len
    always_comb begin
        mask_d = (cfg_we[2] && !busy) ? cfg_di[16 +: NPORTS] : mask_q;
        irq_en_d = (cfg_we[3] && !busy) ? cfg_di[25] : irq_en_q;
        len_d = len_q;
        for (int i = 0; i < LEN_W; i++)
            len_d[i] = (cfg_we[i/8] && !busy) ? cfg_di[i] : len_q[i];
    end

    // Frame sequencer: abort beats everything in WAIT/TX, afull stalls the current byte without advancing
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        wren_d = '0;
        din_d = din_q;
        del_d = del_q;
        done_d = done_q & ~(cfg_we[3] & cfg_di[27]);
        aborted_d = aborted_q & ~(cfg_we[3] & cfg_di[26]);
        case (state_q)
            IDLE: begin
                if (tx_req && !abort_req && mask_d != '0) begin
                    state_d = WAIT;
                    cnt_d = '0;
                end
            end
            WAIT: begin
                if (abort_req) begin
                    state_d = END;
                    done_d = 1'b1;
                    aborted_d = 1'b1;
                end else if (!blocked) begin
                    state_d = TX;
                end
            end
            TX: begin
                if (abort_req) begin
                    state_d = END;
                    done_d = 1'b1;
                    aborted_d = 1'b1;
                end else if (!blocked) begin
                    wren_d = mask_q;
                    din_d = frame_byte;
                    del_d = cnt_q == len_q;
                    state_d = (cnt_q == len_q) ? END : TX;
                    cnt_d = (cnt_q == len_q) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                done_d = 1'b1;
            end
        endcase
    end

    // State, config and output registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            mask_q    <= '0;
            wren_q    <= '0;
            din_q     <= '0;
            del_q     <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            irq_en_q  <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            mask_q    <= mask_d;
            wren_q    <= wren_d;
            din_q     <= din_d;
            del_q     <= del_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            irq_en_q  <= irq_en_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
        end
    end

    // Frame RAM is deliberately unreset; writes while a frame is in flight are dropped
    always_ff @(posedge clk) begin
        if (bus_req && !busy)
            for (int b = 0; b < 4; b++)
                if (iomem_wstrb[b]) mem_q[widx][8*b +: 8] <= iomem_wdata[8*b +: 8];
    end
endmodule

// File: doc/ctrl_frame_tx_engine.md
# ctrl_frame_tx_engine

Parametrised control-frame transmitter for the L2 switch. The picosoc firmware writes a frame of up to 4·2^RAM_AW bytes into a local word RAM over the iomem bus, then starts transmission through a config register. The block streams the frame byte-by-byte into any subset of NPORTS PHY-TX FIFOs. It pauses per byte on FIFO almost-full, supports abort, and reports completion through a sticky status bit and an interrupt.

## Interface
- NPORTS, 4: number of PHY-TX FIFOs (1..8).
- RAM_AW, 4: frame RAM word-address width (2^RAM_AW 32-bit words, 1..8).
- LEN_W, RAM_AW+2: byte-length field width (derived, not overridden).

- clk  in  1  sole clock.
- arst  in  1  asynchronous, active-high reset.
- iomem_valid  in  1  bus request.
- iomem_ready  out  1  registered one-cycle acknowledge.
- iomem_wstrb  in  4  byte write strobes; 0 = read.
- iomem_addr  in  32  byte address; word index = iomem_addr[RAM_AW+1:2].
- iomem_wdata  in  32  write data.
- iomem_rdata  out  32  registered read data, valid with iomem_ready.
- cfg_we  in  4  byte enables for the config register.
- cfg_di  in  32  config write data.
- cfg_do  out  32  config/status readback (combinational from registers).
- fifo_din  out  8  byte to FIFOs, shared by all ports.
- fifo_del  out  1  end-of-frame delimiter, high with the last byte.
- fifo_afull  in  NPORTS  per-port almost-full.
- fifo_wren  out  NPORTS  per-port write enable.
- irq  out  1  level interrupt = done & irq_en.

## Operation
- Config map:
  - [31] tx: W1 starts a frame; reads 0.
  - [30] ready = ~busy (R).
  - [29] busy (R).
  - [28] abort: W1; reads 0.
  - [27] done: sticky, W1C.
  - [26] aborted: sticky, W1C.
  - [25] irq_en (RW).
  - [16+NPORTS-1:16] port mask (RW).
  - [LEN_W-1:0] len = byte count − 1 (RW).
  - Unused bits read 0.
  - Byte lanes: cfg_we[3] covers [31:24], [2] covers [23:16], [1] covers [15:8], [0] covers [7:0].
- While busy, writes to port mask, len and irq_en are ignored. abort, done and aborted W1C remain effective.
- RAM byte order is big-endian: frame byte k = word k>>2, bits [31−8(k&3) -: 8].
- iomem:
  - A request gets iomem_ready exactly one cycle later, for one cycle.
  - Writes honour wstrb per byte.
  - Writes while busy are acknowledged but discarded.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, TX, END.
  - IDLE: a tx write with a nonzero mask latches mask and len, clears cnt, sets busy, and goes to WAIT. A tx write with a zero mask is ignored.
  - WAIT: if (fifo_afull & mask) == 0, go to TX.
  - TX: each cycle, if (fifo_afull & mask) != 0, drive wren = 0 and hold cnt. Otherwise drive wren = mask, din = byte[cnt], del = (cnt == len), and increment cnt. When the del byte is issued, go to END.
  - END: clear busy, set done, go to IDLE.
- Abort in WAIT or TX: wrens go 0 at the next edge, no delimiter is issued, aborted is set, done is set, and the FSM goes to END. Abort in IDLE or END is a no-op.
- If tx and abort are written in the same cycle in IDLE, abort wins and no frame starts.

## Timing
- Reset: all outputs 0, FSM = IDLE, all config fields 0.
- tx written at edge T:
  - WAIT during T+1.
  - TX during T+2.
  - Byte 0 on the FIFO outputs (wren high) in cycle T+3.
- With no afull, byte k appears at T+3+k and the last byte (del = 1) at T+3+len.
- busy falls and done/irq rise at T+4+len.
- A new tx is accepted from T+4+len onward.
- Each afull-blocked cycle adds exactly one cycle; bytes are never skipped or duplicated.
- fifo_din, fifo_del and fifo_wren are registered. din and del are held at their last values while wren = 0; del is only meaningful when wren != 0.
- Reset asserted mid-frame clears everything immediately. No further wren is driven, and there is no partial delimiter.
- The maximum frame is len = 2^LEN_W − 1 (64 B at the defaults); cnt does not wrap past len.

## Test plan
- Write RAM words 0..1 = 0x01020304, 0x05060708; cfg mask=0b0101, len=5, tx → bytes 01..06 on ports 0 and 2 at T+3..T+8, del high only with 06, done at T+9, irq when irq_en=1.
- Same frame, with afull[2] held high for 3 cycles mid-frame → stream stalls exactly 3 cycles, byte order intact, ports 1 and 3 wren never high.
- len=63 at default params → 64 bytes, last byte = RAM word 15 [7:0], del on byte 63, cnt stops.
- Abort written during TX after 2 bytes → wren=0 next cycle, no del, aborted=1, busy=0; W1C of done/aborted clears them and irq.
- tx with mask=0, and tx+abort in the same cycle → no wren, busy stays 0; iomem write while busy is acked but readback shows the old data.
- arst pulse mid-frame → all outputs 0 asynchronously, FSM IDLE, cfg_do=0x40000000.
